// File: rtl/conv_add_tree.sv
// conv_add_tree: pipelined signed adder tree with bias and saturating/wrapping output.
//
// Stage 0 registers the N_IN lanes plus bias. Each tree level k (1..LG) registers
// N_IN/2^k pairwise sums at width DW+k, with bias riding alongside. The final stage
// adds the bias, then clamps (SAT=1) or wraps (SAT=0) the result to DW bits.
// Latency is LG+2 en-qualified edges, and the pipeline accepts one sample per cycle.
//
// Ports
//   clk, rst_b    clock, asynchronous active-low reset
//   en            pipeline advance; 0 holds every register
//   clr           synchronous flush of valid bits and out_count; data registers hold
//   in_valid      in_data/bias carry a sample
//   in_data       N_IN signed lanes, lane i at [i*DW +: DW]
//   bias          signed value added to the lane sum
//   out_valid     new result on out_data/out_ovf
//   out_data      signed result
//   out_ovf       result was clamped or wrapped
//   out_count     results produced since reset or clr (wraps at 16 bits)
module conv_add_tree #(
    parameter int N_IN = 8,
    parameter int DW   = 32,
    parameter int SAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [N_IN*DW-1:0]   in_data,
    input  logic [DW-1:0]        bias,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic                 out_ovf,
    output logic [15:0]          out_count
);

    localparam int LG = $clog2(N_IN);
    localparam int SW = DW + LG + 1;

    // Bit offset of tree level k inside the flat tree register.
    // Level k holds N_IN>>k entries, each DW+k bits wide.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o = o + (N_IN >> j) * (DW + j);
        end
        return o;
    endfunction

    localparam int TREE_W  = lvl_off(LG + 1);
    localparam int TOP_OFF = lvl_off(LG);
    localparam int BIAS_W  = (LG + 1) * DW;

    logic [TREE_W-1:0] tree_q, tree_d, tree_nxt, tree_ld;
    logic [BIAS_W-1:0] bias_q, bias_d, bias_nxt, bias_ld;
    logic [LG:0]       vld_q, vld_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic [15:0]       out_count_q, out_count_d;

    // Per-level next values and load enables. Each level is a bit-mask, so a
    // single flat register can hold levels of different widths.
    for (genvar k = 0; k <= LG; k++) begin : g_lvl
        localparam int OFF = lvl_off(k);
        localparam int W   = DW + k;
        localparam int NS  = N_IN >> k;
        logic ld;

        if (k == 0) begin : g_in
            assign ld = en & in_valid & ~clr;
            assign tree_nxt[OFF +: NS*W] = in_data;
            assign bias_nxt[0 +: DW]     = bias;
        end else begin : g_add
            localparam int POFF = lvl_off(k - 1);
            assign ld = en & vld_q[k-1] & ~clr;
            for (genvar i = 0; i < NS; i++) begin : g_pair
                logic [W-2:0] a, b;
                assign a = tree_q[POFF + (2*i)*(W-1)   +: W-1];
                assign b = tree_q[POFF + (2*i+1)*(W-1) +: W-1];
                assign tree_nxt[OFF + i*W +: W] = {a[W-2], a} + {b[W-2], b};
            end
            assign bias_nxt[k*DW +: DW] = bias_q[(k-1)*DW +: DW];
        end

        assign tree_ld[OFF +: NS*W]  = {(NS*W){ld}};
        assign bias_ld[k*DW +: DW]   = {DW{ld}};
    end

    // Final stage: full-precision sum, then format.
    logic [DW+LG-1:0] tree_sum;
    logic [DW-1:0]    bias_fin;
    logic [SW-1:0]    s_full;
    logic [LG+1:0]    s_hi;
    logic             fits;
    logic [DW-1:0]    fmt_data;
    logic             fmt_ovf;

    assign tree_sum = tree_q[TOP_OFF +: DW+LG];
    assign bias_fin = bias_q[LG*DW +: DW];
    assign s_full   = {tree_sum[DW+LG-1], tree_sum} + {{(LG+1){bias_fin[DW-1]}}, bias_fin};
    // The result fits in DW bits when every bit from the DW-1 sign position up is equal.
    assign s_hi     = s_full[SW-1:DW-1];
    assign fits     = (&s_hi) | ~(|s_hi);

    always_comb begin
        fmt_data = s_full[DW-1:0];
        fmt_ovf  = ~fits;
        if ((SAT != 0) && !fits) begin
            fmt_data = s_full[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_comb begin
        tree_d      = (tree_nxt & tree_ld) | (tree_q & ~tree_ld);
        bias_d      = (bias_nxt & bias_ld) | (bias_q & ~bias_ld);
        vld_d       = vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        if (clr) begin
            vld_d       = '0;
            out_valid_d = 1'b0;
            out_count_d = '0;
        end else if (en) begin
            vld_d       = {vld_q[LG-1:0], in_valid};
            out_valid_d = vld_q[LG];
            if (vld_q[LG]) begin
                out_data_d  = fmt_data;
                out_ovf_d   = fmt_ovf;
                out_count_d = out_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tree_q      <= '0;
            bias_q      <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            tree_q      <= tree_d;
            bias_q      <= bias_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_conv_add_tree.sv
// tb_conv_add_tree: bench for conv_add_tree (N_IN=8, DW=32).
// Two instances share the inputs: dut_s (saturating) and dut_w (wrapping).
// A reference model computes each result arithmetically when the sample is
// accepted and releases it after the pipeline delay, counted in en-qualified edges.
module tb_conv_add_tree;

    localparam int N_IN = 8;
    localparam int DW   = 32;
    localparam int LG   = 3;

    logic                 clk;
    logic                 rst_b;
    logic                 en;
    logic                 clr;
    logic                 in_valid;
    logic [N_IN*DW-1:0]   in_data;
    logic [DW-1:0]        bias;

    logic                 s_out_valid, w_out_valid;
    logic [DW-1:0]        s_out_data, w_out_data;
    logic                 s_out_ovf, w_out_ovf;
    logic [15:0]          s_out_count, w_out_count;

    conv_add_tree #(.N_IN(N_IN), .DW(DW), .SAT(1)) dut_s (
        .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .in_valid(in_valid),
        .in_data(in_data), .bias(bias), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .out_count(s_out_count)
    );

    conv_add_tree #(.N_IN(N_IN), .DW(DW), .SAT(0)) dut_w (
        .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .in_valid(in_valid),
        .in_data(in_data), .bias(bias), .out_valid(w_out_valid),
        .out_data(w_out_data), .out_ovf(w_out_ovf), .out_count(w_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        int          due;
        logic [31:0] sd;
        logic        so;
        logic [31:0] wd;
        logic        wo;
    } exp_t;

    exp_t        pend[$];
    int          edge_n;
    logic        m_vld;
    logic [31:0] m_sd, m_wd;
    logic        m_so, m_wo;
    logic [15:0] m_cnt;
    logic        last_en;

    function automatic exp_t ref_calc(input logic [N_IN*DW-1:0] d, input logic [DW-1:0] b, input int due);
        exp_t   e;
        longint s;
        longint mx;
        longint mn;
        s  = 0;
        mx = 64'sh7FFF_FFFF;
        mn = -64'sh8000_0000;
        for (int i = 0; i < N_IN; i++) s = s + longint'($signed(d[i*DW +: DW]));
        s = s + longint'($signed(b));
        e.due = due;
        if (s > mx) begin
            e.sd = 32'h7FFF_FFFF; e.so = 1'b1;
        end else if (s < mn) begin
            e.sd = 32'h8000_0000; e.so = 1'b1;
        end else begin
            e.sd = s[31:0]; e.so = 1'b0;
        end
        e.wd = s[31:0];
        e.wo = (longint'($signed(e.wd)) != s);
        return e;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pend.delete();
            edge_n = 0; m_vld = 0; m_sd = 0; m_so = 0; m_wd = 0; m_wo = 0;
            m_cnt = 0; last_en = 0;
        end else if (clr) begin
            pend.delete();
            m_vld = 0; m_cnt = 0; last_en = 0;
        end else if (en) begin
            exp_t e;
            edge_n++;
            last_en = 1;
            m_vld = 0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                e = pend.pop_front();
                m_vld = 1; m_sd = e.sd; m_so = e.so; m_wd = e.wd; m_wo = e.wo;
                m_cnt = m_cnt + 16'd1;
            end
            if (in_valid) pend.push_back(ref_calc(in_data, bias, edge_n + LG + 1));
        end else begin
            last_en = 0;
        end
    end

    // Per-cycle comparison against the model, plus an observation log.
    logic [31:0] obs_q[$];
    int          seen;

    always @(negedge clk) begin
        chk("s_vld", s_out_valid, m_vld);
        chk("s_data", s_out_data, m_sd);
        chk("s_ovf", s_out_ovf, m_so);
        chk("s_cnt", s_out_count, m_cnt);
        chk("w_vld", w_out_valid, m_vld);
        chk("w_data", w_out_data, m_wd);
        chk("w_ovf", w_out_ovf, m_wo);
        chk("w_cnt", w_out_count, m_cnt);
        if (s_out_valid) seen++;
        if (s_out_valid && last_en) obs_q.push_back(s_out_data);
    end

    task automatic drive(input logic e, input logic c, input logic v,
                         input logic [N_IN*DW-1:0] d, input logic [DW-1:0] b);
        @(negedge clk);
        en = e; clr = c; in_valid = v; in_data = d; bias = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_wait(input logic [N_IN*DW-1:0] d, input logic [DW-1:0] b);
        drive(1'b1, 1'b0, 1'b1, d, b);
        idle(LG + 1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_lane();
        logic [31:0] r;
        case ($urandom_range(0, 4))
            0, 1:    r = $urandom;
            2:       r = 32'($signed($urandom_range(0, 200)) - 100);
            3:       r = 32'h7FFF_FFFF;
            default: r = 32'h8000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [N_IN*DW-1:0] lane0(input logic [31:0] v);
        logic [N_IN*DW-1:0] d;
        d = '0;
        d[31:0] = v;
        return d;
    endfunction

    initial begin
        logic [N_IN*DW-1:0] d;
        rst_b = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0;
        #1;
        chk("rst_vld", s_out_valid, 1'b0);
        chk("rst_data", s_out_data, 32'h0);
        chk("rst_cnt", s_out_count, 16'h0);
        @(negedge clk);
        rst_b = 1'b1;

        // Eight lanes of 1, zero bias.
        pulse_wait({N_IN{32'd1}}, 32'd0);
        chk("r033_vld", s_out_valid, 1'b1);
        chk("r033_data", s_out_data, 32'd8);
        chk("r033_ovf", s_out_ovf, 1'b0);
        chk("r033_cnt", s_out_count, 16'd1);

        // Positive overflow: clamp vs wrap.
        pulse_wait({N_IN{32'h7FFF_FFFF}}, 32'd0);
        chk("r034_sdata", s_out_data, 32'h7FFF_FFFF);
        chk("r034_sovf", s_out_ovf, 1'b1);
        chk("r034_wdata", w_out_data, 32'hFFFF_FFF8);
        chk("r034_wovf", w_out_ovf, 1'b1);

        // Negative overflow with -1 bias.
        pulse_wait({N_IN{32'h8000_0000}}, 32'hFFFF_FFFF);
        chk("r035_sdata", s_out_data, 32'h8000_0000);
        chk("r035_sovf", s_out_ovf, 1'b1);

        // Mixed signs summing to zero.
        d = '0;
        d[31:0]  = 32'd5;
        d[63:32] = 32'hFFFF_FFFD;
        pulse_wait(d, 32'hFFFF_FFFE);
        chk("r035_zdata", s_out_data, 32'd0);
        chk("r035_zovf", s_out_ovf, 1'b0);

        // Back-to-back samples with a 3-cycle stall while the first result is presented.
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        obs_q.delete();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b1, lane0(32'(i)), 32'd0);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, lane0(32'd99), 32'd7);
        idle(8);
        @(negedge clk);
        chk("r036_cnt", s_out_count, 16'd4);
        chk("r036_nobs", 64'(obs_q.size()), 64'd4);
        for (int i = 0; i < obs_q.size(); i++) chk("r036_order", obs_q[i], 32'(i + 1));

        // Reset with two samples in flight.
        drive(1'b1, 1'b0, 1'b1, lane0(32'd11), 32'd1);
        drive(1'b1, 1'b0, 1'b1, lane0(32'd12), 32'd1);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("r037_data", s_out_data, 32'd0);
        chk("r037_cnt", s_out_count, 16'd0);
        chk("r037_vld", s_out_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        seen = 0;
        idle(10);
        @(negedge clk);
        chk("r037_noval", 64'(seen), 64'd0);
        chk("r037_cnt2", s_out_count, 16'd0);

        // clr with en low and three samples in flight.
        pulse_wait({N_IN{32'd2}}, 32'd3);
        chk("r038_pre", s_out_count, 16'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, lane0(32'(20 + i)), 32'd0);
        drive(1'b0, 1'b1, 1'b1, lane0(32'd50), 32'd0);
        @(negedge clk);
        chk("r038_vld", s_out_valid, 1'b0);
        chk("r038_cnt", s_out_count, 16'd0);
        seen = 0;
        idle(10);
        @(negedge clk);
        chk("r038_noval", 64'(seen), 64'd0);
        chk("r038_hold", s_out_data, 32'd19);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < N_IN; l++) d[l*DW +: DW] = rand_lane();
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 6, d, rand_lane());
        end
        idle(8);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
